// File: rtl/axi_interconnect_pkg.sv
// Types and constants shared by the AXI read and write interconnect paths.
package axi_interconnect_pkg;

  typedef enum logic [1:0] {
    ARBITRATE     = 2'd0,
    ISSUE_ADDRESS = 2'd1,
    ACTIVE_BURST  = 2'd2
  } burst_state_t;

  localparam logic [31:0] M1_BASE_ADDRESS_DEFAULT = 32'hfffee000;

endpackage

// File: rtl/axi_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant is updated only when a grant is taken.
module axi_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       last_grant
);

  logic r_last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (advance) begin
      r_last_grant <= grant;
    end
  end

  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~r_last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign last_grant = r_last_grant;

endmodule

// File: rtl/axi_read_interconnect.sv
// 2x2 AXI read router, one burst in flight. Optional counters under AXI_READ_STATS_EN.
module axi_read_interconnect
  import axi_interconnect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter logic [31:0] M1_BASE_ADDRESS = M1_BASE_ADDRESS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef AXI_READ_STATS_EN
  output logic [31:0]           rd_bursts_0,
  output logic [31:0]           rd_bursts_1,
  output logic [31:0]           rd_beats,
`endif
  input  logic [31:0]           s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  input  logic [31:0]           s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [31:0]           m0_araddr,
  output logic [7:0]            m0_arlen,
  output logic                  m0_arvalid,
  input  logic                  m0_arready,
  input  logic                  m0_rvalid,
  output logic                  m0_rready,
  input  logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [31:0]           m1_araddr,
  output logic [7:0]            m1_arlen,
  output logic                  m1_arvalid,
  input  logic                  m1_arready,
  input  logic                  m1_rvalid,
  output logic                  m1_rready,
  input  logic [DATA_WIDTH-1:0] m1_rdata
);

  burst_state_t          r_state, w_state_next;
  logic                  r_tgt, w_tgt_next;
  logic [31:0]           r_addr, w_addr_next;
  logic [7:0]            r_remaining, w_remaining_next;
  logic [1:0]            w_req;
  logic                  w_advance, w_arb_grant, w_last_grant;
  logic [31:0]           w_sel_addr;
  logic [7:0]            w_sel_len;
  logic                  w_m_arready_sel, w_m_rvalid_sel, w_s_rready_sel, w_beat;
  logic [DATA_WIDTH-1:0] w_m_rdata_sel;

  assign w_req     = {s1_arvalid, s0_arvalid};
  assign w_advance = (r_state == ARBITRATE) && (w_req != 2'b00);

  // last_grant is captured on the same edge as the burst, so it serves as the held grant.
  axi_rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (w_req),
    .advance    (w_advance),
    .grant      (w_arb_grant),
    .last_grant (w_last_grant)
  );

  assign w_sel_addr      = w_arb_grant ? s1_araddr : s0_araddr;
  assign w_sel_len       = w_arb_grant ? s1_arlen : s0_arlen;
  assign w_m_arready_sel = r_tgt ? m1_arready : m0_arready;
  assign w_m_rvalid_sel  = r_tgt ? m1_rvalid : m0_rvalid;
  assign w_m_rdata_sel   = r_tgt ? m1_rdata : m0_rdata;
  assign w_s_rready_sel  = w_last_grant ? s1_rready : s0_rready;
  assign w_beat          = (r_state == ACTIVE_BURST) && w_m_rvalid_sel && w_s_rready_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARBITRATE;
      r_tgt       <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tgt       <= w_tgt_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_tgt_next       = r_tgt;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    s0_rdata   = '0;
    s1_rdata   = '0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_araddr  = '0;
    m1_araddr  = '0;
    m0_arlen   = '0;
    m1_arlen   = '0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    unique case (r_state)
      ARBITRATE: begin
        if (w_advance) begin
          // No acceptance while reset holds the state registers.
          s0_arready       = ~reset & ~w_arb_grant;
          s1_arready       = ~reset & w_arb_grant;
          w_addr_next      = w_sel_addr;
          w_remaining_next = w_sel_len;
          w_tgt_next       = (w_sel_addr >= M1_BASE_ADDRESS);
          w_state_next     = ISSUE_ADDRESS;
        end
      end
      ISSUE_ADDRESS: begin
        if (r_tgt) begin
          m1_arvalid = 1'b1;
          m1_araddr  = r_addr;
          m1_arlen   = r_remaining;
        end else begin
          m0_arvalid = 1'b1;
          m0_araddr  = r_addr;
          m0_arlen   = r_remaining;
        end
        if (w_m_arready_sel) w_state_next = ACTIVE_BURST;
      end
      ACTIVE_BURST: begin
        if (w_last_grant) begin
          s1_rvalid = w_m_rvalid_sel;
          s1_rdata  = w_m_rdata_sel;
        end else begin
          s0_rvalid = w_m_rvalid_sel;
          s0_rdata  = w_m_rdata_sel;
        end
        if (r_tgt) m1_rready = w_s_rready_sel;
        else       m0_rready = w_s_rready_sel;
        if (w_beat) begin
          if (r_remaining == 8'd0) w_state_next = ARBITRATE;
          else                     w_remaining_next = r_remaining - 8'd1;
        end
      end
      default: w_state_next = ARBITRATE;
    endcase
  end

`ifdef AXI_READ_STATS_EN
  logic [31:0] r_bursts_0, r_bursts_1, r_beats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bursts_0 <= '0;
      r_bursts_1 <= '0;
      r_beats    <= '0;
    end else if (w_beat) begin
      r_beats <= r_beats + 32'd1;
      if (r_remaining == 8'd0) begin
        if (w_last_grant) r_bursts_1 <= r_bursts_1 + 32'd1;
        else              r_bursts_0 <= r_bursts_0 + 32'd1;
      end
    end
  end

  assign rd_bursts_0 = r_bursts_0;
  assign rd_bursts_1 = r_bursts_1;
  assign rd_beats    = r_beats;
`endif

endmodule
